norm_shift_ctrl: RTL

- Sequencing controller for the 25-bit five-stage barrel left shifter (`shiftleft`) in the MULT2 multiplier normalization path.
- Accepts an unnormalized 25-bit product mantissa plus biased exponent over a valid/ready handshake.
- Computes leading-zero count and an exponent-clamped shift amount, drives the shifter's 5-bit select, and returns the normalized mantissa, adjusted exponent and status flags over a second valid/ready handshake.
- Contains one shifter instance; one operation in flight at a time.

---
 rtl/norm_shift_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/norm_shift_ctrl.sv
// Normalization sequencer for the MULT2 product mantissa: finds the leading-zero count,
// clamps the shift to the exponent, drives a five-stage left shifter and returns the result.

module shiftleft (
    input  logic [24:0] data,
    input  logic [4:0]  sel,
    output logic [24:0] result
);
    logic [24:0] s0, s1, s2, s3;

    assign s0     = sel[0] ? {data[23:0], 1'b0}  : data;
    assign s1     = sel[1] ? {s0[22:0],  2'b0}   : s0;
    assign s2     = sel[2] ? {s1[20:0],  4'b0}   : s1;
    assign s3     = sel[3] ? {s2[16:0],  8'b0}   : s2;
    assign result = sel[4] ? {s3[8:0],  16'b0}   : s3;
endmodule

// state | meaning
// IDLE  | in_ready high; capture operand when in_valid
// CALC  | leading-zero count and clamped shift registered
// SHIFT | shifter driven with registered shift, output registers loaded
// DONE  | out_valid high until downstream accepts
module norm_shift_ctrl #(
    parameter int EXP_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_mant,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [24:0]      out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_underflow,
    output logic [CNT_W-1:0] done_cnt
);
    typedef enum logic [1:0] {IDLE, CALC, SHIFT, DONE} state_t;

    state_t state, state_nxt;
    logic capture, calc_en, load_en, retire;

    logic [24:0]      op_mant;
    logic [EXP_W-1:0] op_exp;
    logic [4:0]       lzc_c, sh_c, lzc_r, sh_r;
    logic             zero_c, zero_r;
    logic [24:0]      shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        calc_en   = 1'b0;
        load_en   = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                capture   = 1'b1;
                state_nxt = CALC;
            end
            CALC: begin
                calc_en   = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                load_en   = 1'b1;
                state_nxt = DONE;
            end
            DONE: if (out_ready) begin
                retire    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);

    // Ascending scan: the highest set bit is the last one to write lzc_c.
    always_comb begin
        lzc_c = 5'd25;
        for (int i = 0; i < 25; i++) begin
            if (op_mant[i]) lzc_c = 5'(24 - i);
        end
    end

    // When the clamp is taken, exp < lzc <= 24, so exp[4:0] is the whole exponent.
    always_comb begin
        zero_c = (op_mant == 25'd0);
        sh_c   = 5'd0;
        if (!zero_c) begin
            if ((EXP_W+5)'(lzc_c) <= (EXP_W+5)'(op_exp)) sh_c = lzc_c;
            else                                         sh_c = op_exp[4:0];
        end
    end

    shiftleft u_shift (
        .data   (op_mant),
        .sel    (sh_r),
        .result (shifted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_mant       <= '0;
            op_exp        <= '0;
            lzc_r         <= '0;
            sh_r          <= '0;
            zero_r        <= 1'b0;
            out_valid     <= 1'b0;
            out_mant      <= '0;
            out_exp       <= '0;
            out_zero      <= 1'b0;
            out_underflow <= 1'b0;
            done_cnt      <= '0;
        end else begin
            if (capture) begin
                op_mant <= in_mant;
                op_exp  <= in_exp;
            end
            if (calc_en) begin
                lzc_r  <= lzc_c;
                sh_r   <= sh_c;
                zero_r <= zero_c;
            end
            if (load_en) begin
                out_valid     <= 1'b1;
                out_mant      <= shifted;
                out_exp       <= zero_r ? '0 : op_exp - EXP_W'(sh_r);
                out_zero      <= zero_r;
                // A clamped shift is exactly the nonzero case where the shift fell short of lzc.
                out_underflow <= !zero_r && (lzc_r != sh_r);
            end
            if (retire) begin
                out_valid <= 1'b0;
                done_cnt  <= done_cnt + 1'b1;
            end
        end
    end
endmodule
